integrator_decim: RTL and testbench

//   Integrator stage of the DFE integrator-comb (CIC) decimation filter; the counterpart of the comb stage.

---
 rtl/dfe_pkg.sv | 12 +
 rtl/integrator_decim_if.sv | 14 +
 rtl/integ_decim_ctr.sv | 35 +++
 rtl/integrator_decim.sv | 91 +++++++++
 tb/tb_integrator_decim.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dfe_pkg.sv
// Shared constants for the DFE CIC decimator, used by both the integrator and comb stages.
package dfe_pkg;
    localparam int DFE_I_BW       = 8;
    localparam int DFE_O_BW       = 16;
    localparam int DFE_DECIM_RATE = 250;
    localparam int DFE_CNT_W      = $clog2(DFE_DECIM_RATE);

    // Two's-complement add overflow: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction
endpackage

// File: rtl/integrator_decim_if.sv
// Sample stream into the integrator and decimated stream out of it.
interface integrator_decim_if import dfe_pkg::*; #(
    parameter int I_BW = DFE_I_BW,
    parameter int O_BW = DFE_O_BW
);
    logic [I_BW-1:0] data_i;
    logic            valid_i;
    logic [O_BW-1:0] data_o;
    logic            valid_o;
    logic            ovf_o;

    modport master (output data_i, output valid_i, input data_o, input valid_o, input ovf_o);
    modport slave  (input data_i, input valid_i, output data_o, output valid_o, output ovf_o);
endinterface

// File: rtl/integ_decim_ctr.sv
// Decimation phase counter: counts 0..RATE-1 on inc, clr zeroes it; wrap_o flags the terminal count.
module integ_decim_ctr import dfe_pkg::*; #(
    parameter int RATE  = DFE_DECIM_RATE,
    parameter int CNT_W = $clog2(RATE)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc,
    input  logic clr,
    output logic wrap_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign wrap_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/integrator_decim.sv
// CIC integrator with decimated output: wrapping accumulator, one output every DECIM_RATE accepts.
// Optional sticky overflow flag built only when INTEG_OVF_FLAG_EN is defined.
module integrator_decim import dfe_pkg::*; #(
    parameter int I_BW       = DFE_I_BW,
    parameter int O_BW       = DFE_O_BW,
    parameter int DECIM_RATE = DFE_DECIM_RATE
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               en_i,
    integrator_decim_if.slave  bus
);
    logic signed [I_BW-1:0] din;
    logic [O_BW-1:0]        din_ext;
    logic [O_BW-1:0]        sum;
    logic [O_BW-1:0]        acc_q, acc_d;
    logic [O_BW-1:0]        data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   accept;
    logic                   wrap;

    assign din     = bus.data_i;
    assign din_ext = O_BW'(din);
    // Wraps modulo 2^O_BW on purpose; the comb stages cancel it downstream.
    assign sum     = acc_q + din_ext;
    assign accept  = en_i & bus.valid_i;

    integ_decim_ctr #(.RATE(DECIM_RATE)) u_ctr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc     (accept),
        .clr     (~en_i),
        .wrap_o  (wrap)
    );

    always_comb begin
        acc_d   = acc_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (!en_i) begin
            acc_d  = '0;
            data_d = '0;
        end else if (bus.valid_i) begin
            acc_d = sum;
            if (wrap) begin
                data_d  = sum;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;

`ifdef INTEG_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (!en_i) begin
            ovf_d = 1'b0;
        end else if (accept && add_ovf(acc_q[O_BW-1], din_ext[O_BW-1], sum[O_BW-1])) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf_o = ovf_q;
`else
    assign bus.ovf_o = 1'b0;
`endif
endmodule

// File: tb/tb_integrator_decim.sv
// Directed + randomized bench for integrator_decim, checked against an integer-arithmetic CIC model.
module tb_integrator_decim;
    import dfe_pkg::*;

    localparam int IW   = DFE_I_BW;
    localparam int OW   = DFE_O_BW;
    localparam int R    = DFE_DECIM_RATE;
    localparam int HALF = 2 ** (OW - 1);
    localparam int FULL = 2 ** OW;
`ifdef INTEG_OVF_FLAG_EN
    localparam logic OVF_BUILT = 1'b1;
`else
    localparam logic OVF_BUILT = 1'b0;
`endif

    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    logic en_i    = 1'b0;

    integrator_decim_if #(.I_BW(IW), .O_BW(OW)) bus ();

    integrator_decim #(.I_BW(IW), .O_BW(OW), .DECIM_RATE(R)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model: signed running sum kept in plain integers.
    int              m_acc;
    int              m_cnt;
    logic [OW-1:0]   m_data;
    logic            m_valid;
    logic            m_ovf;
    int              n_acc;
    logic [OW-1:0]   outs[$];
    int              out_at[$];

    function automatic int wrap_s(input int v);
        int r;
        r = v % FULL;
        if (r < 0) r += FULL;
        if (r >= HALF) r -= FULL;
        return r;
    endfunction

    function automatic logic signed [IW-1:0] rnd();
        return IW'($urandom);
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc   = 0;
        m_cnt   = 0;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic v, input logic signed [IW-1:0] d);
        int s;
        if (!rst_n_i || !en) begin
            model_clear();
        end else begin
            m_valid = 1'b0;
            if (v) begin
                s = m_acc + int'(d);
                if (OVF_BUILT && (s >= HALF || s < -HALF)) m_ovf = 1'b1;
                m_acc = wrap_s(s);
                m_cnt++;
                n_acc++;
                if (m_cnt == R) begin
                    m_cnt   = 0;
                    m_valid = 1'b1;
                    m_data  = OW'(m_acc);
                end
            end
        end
    endtask

    task automatic step(input logic en, input logic v, input logic signed [IW-1:0] d);
        en_i        = en;
        bus.valid_i = v;
        bus.data_i  = d;
        @(posedge clk_i);
        model_edge(en, v, d);
        #1;
        chk("valid_o", OW'(bus.valid_o), OW'(m_valid));
        chk("data_o", bus.data_o, m_data);
        chk("ovf_o", OW'(bus.ovf_o), OW'(m_ovf));
        if (bus.valid_o === 1'b1) begin
            outs.push_back(bus.data_o);
            out_at.push_back(n_acc);
        end
    endtask

    task automatic clear_phase();
        step(1'b0, 1'b1, rnd());
        outs.delete();
        out_at.delete();
        n_acc = 0;
    endtask

    initial begin
        logic signed [IW-1:0] d;
        logic [OW-1:0]        ref_q[$];
        logic [OW-1:0]        prev;
        logic [OW-1:0]        comb;
        logic                 v;
        int                   budget;
        int                   s5;
        int                   blk;
        int                   k;

        bus.data_i  = '0;
        bus.valid_i = 1'b0;
        model_clear();
        n_acc = 0;

        // 1. Reset state, then async reset mid-count at cnt=100.
        repeat (3) step(1'b1, 1'b1, 8'sd5);
        rst_n_i = 1'b1;
        repeat (100) step(1'b1, 1'b1, rnd());
        chk_int("t1_no_early_pulse", outs.size(), 0);
        #2 rst_n_i = 1'b0;
        #1;
        model_clear();
        chk("t1_async_data", bus.data_o, '0);
        chk("t1_async_valid", OW'(bus.valid_o), '0);
        chk("t1_async_ovf", OW'(bus.ovf_o), '0);
        repeat (2) step(1'b1, 1'b1, rnd());
        rst_n_i = 1'b1;
        outs.delete();
        out_at.delete();
        n_acc = 0;
        repeat (R) step(1'b1, 1'b1, rnd());
        chk_int("t1_pulses", outs.size(), 1);
        chk_int("t1_first_at", (out_at.size() > 0) ? out_at[0] : -1, R);

        // 2. DC input of 1 for 750 accepts.
        clear_phase();
        repeat (3 * R) step(1'b1, 1'b1, 8'sd1);
        chk_int("t2_pulses", outs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_value", (outs.size() > i) ? outs[i] : '0, OW'((i + 1) * R));
            chk_int("t2_at", (out_at.size() > i) ? out_at[i] : -1, (i + 1) * R);
        end

        // 3. Gapped valid_i at ~30% duty, data -2.
        clear_phase();
        budget = 0;
        while (n_acc < R && budget < 5000) begin
            budget++;
            v = ($urandom_range(99) < 30);
            step(1'b1, v, -8'sd2);
        end
        repeat (5) step(1'b1, 1'b0, -8'sd2);
        chk_int("t3_accepts", n_acc, R);
        chk_int("t3_pulses", outs.size(), 1);
        chk("t3_value", (outs.size() > 0) ? outs[0] : '0, 16'hFE0C);
        chk_int("t3_at", (out_at.size() > 0) ? out_at[0] : -1, R);

        // 4. Walk the accumulator up to 0x7FFF and across into 0x8000.
        clear_phase();
        repeat (258) step(1'b1, 1'b1, 8'sd127);
        step(1'b1, 1'b1, 8'sd1);
        step(1'b1, 1'b1, 8'sd1);
        repeat (240) step(1'b1, 1'b1, 8'sd0);
        chk_int("t4_pulses", outs.size(), 2);
        chk("t4_first", (outs.size() > 0) ? outs[0] : '0, 16'h7C06);
        chk("t4_wrapped", (outs.size() > 1) ? outs[1] : '0, 16'h8000);
        chk("t4_ovf", OW'(bus.ovf_o), OW'(OVF_BUILT));

        // 5. en_i drop at cnt=249 with valid_i high.
        clear_phase();
        repeat (R - 1) step(1'b1, 1'b1, rnd());
        step(1'b0, 1'b1, rnd());
        chk_int("t5_no_pulse", outs.size(), 0);
        chk("t5_cleared", bus.data_o, '0);
        n_acc = 0;
        s5 = 0;
        repeat (R) begin
            d = rnd();
            s5 += int'(d);
            step(1'b1, 1'b1, d);
        end
        chk_int("t5_pulses", outs.size(), 1);
        chk_int("t5_at", (out_at.size() > 0) ? out_at[0] : -1, R);
        chk("t5_value", (outs.size() > 0) ? outs[0] : '0, OW'(s5));

        // 6. Comb of the DUT output against per-block input sums over 10k samples.
        clear_phase();
        blk = 0;
        k = 0;
        budget = 0;
        while (k < 10000 && budget < 20000) begin
            budget++;
            v = ($urandom_range(99) < 80);
            d = rnd();
            step(1'b1, v, d);
            if (v) begin
                blk += int'(d);
                k++;
                if (k % R == 0) begin
                    ref_q.push_back(OW'(blk));
                    blk = 0;
                end
            end
        end
        repeat (3) step(1'b1, 1'b0, 8'sd0);
        chk_int("t6_samples", k, 10000);
        chk_int("t6_outputs", outs.size(), ref_q.size());
        prev = '0;
        for (int i = 0; i < ref_q.size() && i < outs.size(); i++) begin
            comb = outs[i] - prev;
            prev = outs[i];
            chk("t6_cic", comb, ref_q[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
